aes_decrypt_unit: RTL and testbench

Byte-serial iterative AES-128 decryption core, the inverse-direction counterpart of the iterative encryption unit. It shares that unit's byte-serial handshake and round-key memory addressing. Ciphertext enters one byte per accepted cycle and plaintext leaves one byte per cycle. Rounds execute iteratively over an internal 2×16-byte state store. Round keys come from an external pre-expanded key memory, read combinationally.

---
 rtl/aes_dec_pkg.sv | 47 ++++
 rtl/aes_decrypt_unit_if.sv | 22 ++
 rtl/aes_inv_sub_bytes.sv | 26 ++
 rtl/aes_decrypt_unit.sv | 134 +++++++++++++
 tb/tb_aes_decrypt_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the byte-serial AES-128 decryptor.
// inv_mix_col packs a column as {row0,row1,row2,row3}, row0 in the top byte.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SUB,
        ST_MIX,
        ST_OUT
    } dec_state_t;

    localparam logic [3:0] NR = 4'd10;
    localparam int         NB = 16;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        return {gmul14(b0) ^ gmul11(b1) ^ gmul13(b2) ^ gmul9(b3),
                gmul9(b0)  ^ gmul14(b1) ^ gmul11(b2) ^ gmul13(b3),
                gmul13(b0) ^ gmul9(b1)  ^ gmul14(b2) ^ gmul11(b3),
                gmul11(b0) ^ gmul13(b1) ^ gmul9(b2)  ^ gmul14(b3)};
    endfunction

endpackage

// File: rtl/aes_decrypt_unit_if.sv
// Byte-serial ciphertext/plaintext handshake plus the combinational round-key memory port.
// slave is the decryptor side; master is the host/key-memory side.
interface aes_decrypt_unit_if;
    logic       valid_input;
    logic [7:0] data_in;
    logic       ready;
    logic       valid_output;
    logic [7:0] data_out;
    logic [7:0] key_addr;
    logic [7:0] key;
    logic [3:0] rnd;

    modport slave (
        input  valid_input, data_in, key,
        output ready, valid_output, data_out, key_addr, rnd
    );

    modport master (
        output valid_input, data_in, key,
        input  ready, valid_output, data_out, key_addr, rnd
    );
endinterface

// File: rtl/aes_inv_sub_bytes.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sub_bytes (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_byte = INV_SBOX[in_byte];
endmodule

// File: rtl/aes_decrypt_unit.sv
// Byte-serial iterative AES-128 decryptor over two 16-byte banks; optional AES_DEC_OUTPUT_REG_EN registers the output.
// Latency: first plaintext byte 197 cycles after the last ciphertext byte (198 with the output register).
// Backpressure: ready only in LOAD; valid_input outside LOAD is ignored, output stream cannot be stalled.
module aes_decrypt_unit
    import aes_dec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    aes_decrypt_unit_if.slave bus
);
    dec_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [7:0]  bank_a_q [NB];
    logic [7:0]  bank_a_d [NB];
    logic [7:0]  bank_b_q [NB];
    logic [7:0]  bank_b_d [NB];
    logic [1:0]  src_col;
    logic [7:0]  sbox_in, sbox_out;
    logic [31:0] mix_in, mix_out;

    // InvShiftRows folded into the read address: dest (r,c) pulls from column (c-r) mod 4.
    assign src_col = cnt_q[3:2] - cnt_q[1:0];
    assign sbox_in = bank_a_q[{src_col, cnt_q[1:0]}];

    aes_inv_sub_bytes u_inv_sbox (
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    assign mix_in  = {bank_b_q[{cnt_q[1:0], 2'd0}], bank_b_q[{cnt_q[1:0], 2'd1}],
                      bank_b_q[{cnt_q[1:0], 2'd2}], bank_b_q[{cnt_q[1:0], 2'd3}]};
    assign mix_out = inv_mix_col(mix_in);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;
        bank_a_d = bank_a_q;
        bank_b_d = bank_b_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.valid_input) begin
                    bank_a_d[cnt_q] = bus.data_in ^ bus.key;
                    cnt_d           = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_SUB;
                        rnd_d   = NR - 4'd1;
                    end
                end
            end
            ST_SUB: begin
                bank_b_d[cnt_q] = sbox_out ^ bus.key;
                cnt_d           = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = (rnd_q == 4'd0) ? ST_OUT : ST_MIX;
                end
            end
            ST_MIX: begin
                bank_a_d[{cnt_q[1:0], 2'd0}] = mix_out[31:24];
                bank_a_d[{cnt_q[1:0], 2'd1}] = mix_out[23:16];
                bank_a_d[{cnt_q[1:0], 2'd2}] = mix_out[15:8];
                bank_a_d[{cnt_q[1:0], 2'd3}] = mix_out[7:0];
                cnt_d                        = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    cnt_d   = 4'd0;
                    rnd_d   = rnd_q - 4'd1;
                    state_d = ST_SUB;
                end
            end
            ST_OUT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_LOAD;
                    rnd_d   = NR;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 4'd0;
                rnd_d   = NR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= 4'd0;
            rnd_q   <= NR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end

    // Bank contents are only ever read after being written for the current block.
    always_ff @(posedge clk) begin
        bank_a_q <= bank_a_d;
        bank_b_q <= bank_b_d;
    end

    assign bus.ready    = (state_q == ST_LOAD);
    assign bus.rnd      = rnd_q;
    assign bus.key_addr = {rnd_q, (state_q == ST_LOAD || state_q == ST_SUB) ? cnt_q : 4'd0};

`ifdef AES_DEC_OUTPUT_REG_EN
    logic       out_vld_q, out_vld_d;
    logic [7:0] out_dat_q, out_dat_d;

    always_comb begin
        out_vld_d = (state_q == ST_OUT);
        out_dat_d = out_vld_d ? bank_b_q[cnt_q] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            out_dat_q <= 8'h00;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign bus.valid_output = out_vld_q;
    assign bus.data_out     = out_dat_q;
`else
    assign bus.valid_output = (state_q == ST_OUT);
    assign bus.data_out     = (state_q == ST_OUT) ? bank_b_q[cnt_q] : 8'h00;
`endif

endmodule

// File: tb/tb_aes_decrypt_unit.sv
// Directed FIPS-197 decryption vectors against a bench-expanded round-key memory.
module tb_aes_decrypt_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [7:0] sbox      [256];
    logic [7:0] kmem_c1   [256];
    logic [7:0] kmem_b    [256];
    logic       key_sel;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_unit_if bus ();

    aes_decrypt_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.key = key_sel ? kmem_b[bus.key_addr] : kmem_c1[bus.key_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(b));
            sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k, input bit which);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 256; i++) begin
            if (which) kmem_b[i]  = (i < 176) ? w[i/4][31-8*(i%4) -: 8] : 8'h00;
            else       kmem_c1[i] = (i < 176) ? w[i/4][31-8*(i%4) -: 8] : 8'h00;
        end
    endtask

    // Presents one ciphertext block; returns in the cycle after the 16th byte is accepted.
    task automatic send_block(input logic [127:0] ct, input bit use_b, input int max_gap, input string tag);
        int g;
        int load_err;
        key_sel  = use_b;
        load_err = 0;
        for (int i = 0; i < 16; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                bus.valid_input = 1'b0;
                bus.data_in     = 8'ha5;
                @(posedge clk); #1;
            end
            bus.valid_input = 1'b1;
            bus.data_in     = ct[127-8*i -: 8];
            if (bus.key_addr !== 8'(160 + i) || bus.rnd !== 4'd10 || bus.ready !== 1'b1) load_err++;
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
        chk({tag, "_load_addr_errs"}, load_err, 0);
    endtask

    // Observes cycles T+1..T+212 and stops in cycle T+213 with valid_input low.
    task automatic observe_block(input logic [127:0] pt, input bit garbage, input string tag);
        int n, off, lat, vcnt, ready_hi, addr_err, out_err;
        logic [3:0]   er;
        logic [7:0]   ea;
        logic [127:0] got;
        lat = 0; vcnt = 0; ready_hi = 0; addr_err = 0; out_err = 0; got = '0;
        for (n = 1; n <= 212; n++) begin
            bus.valid_input = garbage;
            bus.data_in     = garbage ? 8'($urandom) : 8'h00;
            off = n - 1;
            if (off < 180) begin
                er = 4'(9 - off / 20);
                ea = (off % 20 < 16) ? 8'(er * 16 + off % 20) : 8'(er * 16);
            end else if (off < 196) begin
                er = 4'd0;
                ea = 8'(off - 180);
            end else begin
                er = 4'd0;
                ea = 8'd0;
            end
            if (bus.rnd !== er || bus.key_addr !== ea) addr_err++;
            if (bus.ready !== 1'b0) ready_hi++;
            if (bus.valid_output === 1'b1) begin
                if (lat == 0) lat = n;
                if (vcnt < 16) got[127-8*vcnt -: 8] = bus.data_out;
                vcnt++;
            end else if (bus.data_out !== 8'h00) begin
                out_err++;
            end
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
        bus.data_in     = 8'h00;
        chk({tag, "_latency"},       lat, 197);
        chk({tag, "_plaintext"},     got, pt);
        chk({tag, "_out_count"},     vcnt, 16);
        chk({tag, "_ready_low"},     ready_hi, 0);
        chk({tag, "_rnd_addr_errs"}, addr_err, 0);
        chk({tag, "_idle_data_out"}, out_err, 0);
        chk({tag, "_ready_t213"},    bus.ready, 1'b1);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        key_sel         = 1'b0;
        reset           = 1'b1;
        bus.valid_input = 1'b0;
        bus.data_in     = 8'h00;
        build_sbox();
        expand(KEY_C1, 1'b0);
        expand(KEY_B,  1'b1);
        chk("sbox_fwd_53", sbox[8'h53], 8'hed);
        chk("kexp_b_last", {kmem_b[172], kmem_b[173], kmem_b[174], kmem_b[175]}, 32'hb6630ca6);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",    bus.ready,        1'b1);
        chk("rst_vout",     bus.valid_output, 1'b0);
        chk("rst_dout",     bus.data_out,     8'h00);
        chk("rst_rnd",      bus.rnd,          4'd10);
        chk("rst_key_addr", bus.key_addr,     8'd160);
        reset = 1'b0;

        send_block(CT_C1, 1'b0, 0, "c1");
        observe_block(PT_C1, 1'b0, "c1");

        send_block(CT_B, 1'b1, 3, "b_gaps");
        observe_block(PT_B, 1'b0, "b_gaps");

        send_block(CT_C1, 1'b0, 0, "c1_garb");
        observe_block(PT_C1, 1'b1, "c1_garb");

        send_block(CT_C1, 1'b0, 0, "c1_rst");
        for (int n = 1; n < 50; n++) begin
            @(posedge clk); #1;
        end
        chk("mid_rnd_t50", bus.rnd, 4'd7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_ready",    bus.ready,        1'b1);
        chk("mid_rst_rnd",      bus.rnd,          4'd10);
        chk("mid_rst_vout",     bus.valid_output, 1'b0);
        chk("mid_rst_key_addr", bus.key_addr,     8'd160);

        send_block(CT_C1, 1'b0, 0, "c1_after_rst");
        observe_block(PT_C1, 1'b0, "c1_after_rst");

        send_block(CT_C1, 1'b0, 0, "b2b_c1");
        observe_block(PT_C1, 1'b0, "b2b_c1");
        send_block(CT_B, 1'b1, 0, "b2b_b");
        observe_block(PT_B, 1'b0, "b2b_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
